// File: rtl/parser_pkg.sv
// Shared types for the UART message path: message kinds from the classifier,
// protocol characters, and the sequencer FSM encoding.
package parser_pkg;

  typedef enum logic [2:0] {
    MSG_NONE        = 3'd0,
    RGF_WRITE       = 3'd1,
    RGF_READ        = 3'd2,
    SINGLE_PIXEL_WR = 3'd3,
    START_BURST_WR  = 3'd4,
    START_BURST_RD  = 3'd5,
    BURST_PIXEL_WR  = 3'd6
  } msg_type_e;

  localparam logic [7:0] CHAR_W  = 8'h57;
  localparam logic [7:0] CHAR_R  = 8'h52;
  localparam logic [7:0] CHAR_P  = 8'h50;
  localparam logic [7:0] CHAR_B  = 8'h42;
  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;

  localparam int unsigned TX_W = 96;

  typedef enum logic [2:0] {
    StIdle,
    StRgfWr,
    StRgfRd,
    StRdResp,
    StBurstWr,
    StBrdIssue,
    StBrdResp
  } seq_state_e;

endpackage

// File: rtl/uart_msg_sequencer_addr_gen.sv
// Burst address generator: word count from image dimensions, word pointer,
// read base, and the last-word flag.
module seq_addr_gen #(
  parameter int unsigned SRAM_AW  = 14,
  parameter int unsigned IMG_BASE = 0,
  parameter int unsigned DIM_W    = 12
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_i,
  input  logic               inc_i,
  input  logic [31:0]        height_i,
  input  logic [31:0]        width_i,
  input  logic [SRAM_AW-1:0] base_i,
  output logic               total_zero_o,
  output logic [SRAM_AW-1:0] wr_addr_o,
  output logic [SRAM_AW-1:0] rd_addr_o,
  output logic               last_o
);

  localparam int unsigned TW = 2 * DIM_W;

  logic [TW-1:0]      prod, total;
  logic [TW-1:0]      ptr_q, ptr_d, total_q, total_d;
  logic [SRAM_AW-1:0] base_q, base_d;
  logic               unused_dims;

  assign unused_dims = ^{height_i[31:DIM_W], width_i[31:DIM_W]};

  // Words needed for H*W pixels at four pixels per word, rounded up.
  assign prod         = TW'(height_i[DIM_W-1:0]) * TW'(width_i[DIM_W-1:0]);
  assign total        = (prod + TW'(3)) >> 2;
  assign total_zero_o = (total == '0);

  assign wr_addr_o = SRAM_AW'(IMG_BASE) + ptr_q[SRAM_AW-1:0];
  assign rd_addr_o = base_q + ptr_q[SRAM_AW-1:0];
  assign last_o    = (ptr_q == total_q - TW'(1));

  always_comb begin
    ptr_d   = ptr_q;
    total_d = total_q;
    base_d  = base_q;
    if (load_i) begin
      ptr_d   = '0;
      total_d = total;
      base_d  = base_i;
    end else if (inc_i) begin
      ptr_d = ptr_q + TW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q   <= '0;
      total_q <= '0;
      base_q  <= '0;
    end else begin
      ptr_q   <= ptr_d;
      total_q <= total_d;
      base_q  <= base_d;
    end
  end

endmodule

// File: rtl/uart_msg_sequencer.sv
// Executes classified UART messages on the RGF bus, the per-channel pixel SRAMs
// and the TX response path; one request interface is active at a time.
module uart_msg_sequencer
  import parser_pkg::*;
#(
  parameter int unsigned SRAM_AW      = 14,
  parameter int unsigned RGF_MAX_ADDR = 31,
  parameter int unsigned IMG_BASE     = 0,
  parameter int unsigned DIM_W        = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               data_available,
  input  msg_type_e          classified_type,
  input  logic [7:0]         parsed_addr,
  input  logic [15:0]        parsed_offset_addr,
  input  logic [15:0]        parsed_data_high,
  input  logic [15:0]        parsed_data_low,
  input  logic [31:0]        parsed_height,
  input  logic [31:0]        parsed_width,
  input  logic [7:0]         pixel_r,
  input  logic [7:0]         pixel_g,
  input  logic [7:0]         pixel_b,
  input  logic [31:0]        burst_red,
  input  logic [31:0]        burst_green,
  input  logic [31:0]        burst_blue,
  output logic               seq_ready,
  output logic               burst_done,
  output logic               rgf_wr_en,
  output logic               rgf_rd_en,
  output logic [7:0]         rgf_addr,
  output logic [31:0]        rgf_wdata,
  input  logic [31:0]        rgf_rdata,
  input  logic               rgf_ack,
  output logic               sram_wr_en,
  output logic               sram_rd_en,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [3:0]         sram_wmask,
  output logic [31:0]        sram_wdata_r,
  output logic [31:0]        sram_wdata_g,
  output logic [31:0]        sram_wdata_b,
  input  logic [31:0]        sram_rdata_r,
  input  logic [31:0]        sram_rdata_g,
  input  logic [31:0]        sram_rdata_b,
  output logic               tx_valid,
  output logic [TX_W-1:0]    tx_data,
  input  logic               tx_ready,
  output logic               err_drop
);

  seq_state_e         state_q, state_d;
  logic [7:0]         addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [TX_W-1:0]    tx_data_q, tx_data_d;
  logic               pix_pend_q, pix_pend_d;
  logic [SRAM_AW-1:0] pix_addr_q, pix_addr_d;
  logic [1:0]         pix_lane_q, pix_lane_d;
  logic [7:0]         pix_r_q, pix_r_d, pix_g_q, pix_g_d, pix_b_q, pix_b_d;
  logic               burst_done_q, burst_done_d;
  logic               cap_q, cap_d;
  logic               gen_load, gen_inc, gen_total_zero, gen_last;
  logic [SRAM_AW-1:0] gen_wr_addr, gen_rd_addr;
  logic               rgf_in_range;

  assign rgf_in_range = ({24'b0, parsed_addr} <= RGF_MAX_ADDR);

  seq_addr_gen #(
    .SRAM_AW  (SRAM_AW),
    .IMG_BASE (IMG_BASE),
    .DIM_W    (DIM_W)
  ) u_addr_gen (
    .clk_i        (clk),
    .rst_i        (rst),
    .load_i       (gen_load),
    .inc_i        (gen_inc),
    .height_i     (parsed_height),
    .width_i      (parsed_width),
    .base_i       (parsed_offset_addr[SRAM_AW+1:2]),
    .total_zero_o (gen_total_zero),
    .wr_addr_o    (gen_wr_addr),
    .rd_addr_o    (gen_rd_addr),
    .last_o       (gen_last)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    tx_data_d    = tx_data_q;
    pix_pend_d   = 1'b0;
    pix_addr_d   = pix_addr_q;
    pix_lane_d   = pix_lane_q;
    pix_r_d      = pix_r_q;
    pix_g_d      = pix_g_q;
    pix_b_d      = pix_b_q;
    burst_done_d = 1'b0;
    cap_d        = 1'b0;
    gen_load     = 1'b0;
    gen_inc      = 1'b0;
    seq_ready    = 1'b0;
    burst_done   = 1'b0;
    rgf_wr_en    = 1'b0;
    rgf_rd_en    = 1'b0;
    rgf_addr     = '0;
    rgf_wdata    = '0;
    sram_wr_en   = 1'b0;
    sram_rd_en   = 1'b0;
    sram_addr    = '0;
    sram_wmask   = '0;
    sram_wdata_r = '0;
    sram_wdata_g = '0;
    sram_wdata_b = '0;
    tx_valid     = 1'b0;
    tx_data      = '0;
    err_drop     = 1'b0;

    // Reset forces every output low, including the registered ones.
    if (!rst) begin
      burst_done = burst_done_q;
      tx_data    = tx_data_q;

      // Deferred single-pixel write; the FSM is always idle in this cycle.
      if (pix_pend_q) begin
        sram_wr_en   = 1'b1;
        sram_addr    = pix_addr_q;
        sram_wmask   = 4'b1000 >> pix_lane_q;
        sram_wdata_r = {pix_r_q, 24'b0} >> {pix_lane_q, 3'b000};
        sram_wdata_g = {pix_g_q, 24'b0} >> {pix_lane_q, 3'b000};
        sram_wdata_b = {pix_b_q, 24'b0} >> {pix_lane_q, 3'b000};
      end

      case (state_q)
        StIdle: begin
          if (data_available) begin
            seq_ready = 1'b1;
            addr_d    = parsed_addr;
            wdata_d   = {parsed_data_high, parsed_data_low};
            case (classified_type)
              RGF_WRITE: begin
                if (rgf_in_range) state_d = StRgfWr;
                else err_drop = 1'b1;
              end
              RGF_READ: begin
                if (rgf_in_range) state_d = StRgfRd;
                else err_drop = 1'b1;
              end
              SINGLE_PIXEL_WR: begin
                pix_pend_d = 1'b1;
                pix_addr_d = parsed_offset_addr[SRAM_AW+1:2];
                pix_lane_d = parsed_offset_addr[1:0];
                pix_r_d    = pixel_r;
                pix_g_d    = pixel_g;
                pix_b_d    = pixel_b;
              end
              START_BURST_WR: begin
                gen_load = 1'b1;
                if (gen_total_zero) burst_done_d = 1'b1;
                else state_d = StBurstWr;
              end
              START_BURST_RD: begin
                gen_load = 1'b1;
                if (!gen_total_zero) state_d = StBrdIssue;
              end
              default: err_drop = 1'b1;
            endcase
          end
        end
        StRgfWr: begin
          rgf_wr_en = 1'b1;
          rgf_addr  = addr_q;
          rgf_wdata = wdata_q;
          if (rgf_ack) state_d = StIdle;
        end
        StRgfRd: begin
          rgf_rd_en = 1'b1;
          rgf_addr  = addr_q;
          if (rgf_ack) begin
            tx_data_d = {{(TX_W-32){1'b0}}, rgf_rdata};
            state_d   = StRdResp;
          end
        end
        StRdResp: begin
          tx_valid = 1'b1;
          if (tx_ready) state_d = StIdle;
        end
        StBurstWr: begin
          if (data_available) begin
            seq_ready = 1'b1;
            if (classified_type == BURST_PIXEL_WR) begin
              sram_wr_en   = 1'b1;
              sram_wmask   = 4'hF;
              sram_addr    = gen_wr_addr;
              sram_wdata_r = burst_red;
              sram_wdata_g = burst_green;
              sram_wdata_b = burst_blue;
              gen_inc      = 1'b1;
              if (gen_last) begin
                burst_done_d = 1'b1;
                state_d      = StIdle;
              end
            end else begin
              err_drop = 1'b1;
            end
          end
        end
        StBrdIssue: begin
          sram_rd_en = 1'b1;
          sram_addr  = gen_rd_addr;
          cap_d      = 1'b1;
          state_d    = StBrdResp;
        end
        StBrdResp: begin
          // First cycle only captures the SRAM read data; the beat is offered after.
          if (cap_q) begin
            tx_data_d = {sram_rdata_r, sram_rdata_g, sram_rdata_b};
          end else begin
            tx_valid = 1'b1;
            if (tx_ready) begin
              gen_inc = 1'b1;
              state_d = gen_last ? StIdle : StBrdIssue;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      wdata_q      <= '0;
      tx_data_q    <= '0;
      pix_pend_q   <= 1'b0;
      pix_addr_q   <= '0;
      pix_lane_q   <= '0;
      pix_r_q      <= '0;
      pix_g_q      <= '0;
      pix_b_q      <= '0;
      burst_done_q <= 1'b0;
      cap_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      tx_data_q    <= tx_data_d;
      pix_pend_q   <= pix_pend_d;
      pix_addr_q   <= pix_addr_d;
      pix_lane_q   <= pix_lane_d;
      pix_r_q      <= pix_r_d;
      pix_g_q      <= pix_g_d;
      pix_b_q      <= pix_b_d;
      burst_done_q <= burst_done_d;
      cap_q        <= cap_d;
    end
  end

endmodule
